// File: rtl/demux_1a4.sv
// Byte demultiplexer: distributes a serial valid-qualified byte stream round-robin into four
// lanes and publishes each completed (or last-terminated) group as one parallel word.
module demux_1a4 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             last_in,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic [WIDTH-1:0] data_out2,
    output logic [WIDTH-1:0] data_out3,
    output logic             valid_out0,
    output logic             valid_out1,
    output logic             valid_out2,
    output logic             valid_out3,
    output logic             group_valid,
    output logic             partial
);

    typedef enum logic [0:0] {
        StIdle,
        StFill
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] shadow_q [4];
    logic [WIDTH-1:0] shadow_d [4];
    logic [3:0]       fill_q, fill_d;

    logic [WIDTH-1:0] dout_q [4];
    logic [WIDTH-1:0] dout_d [4];
    logic [3:0]       vout_q, vout_d;
    logic             group_valid_q, group_valid_d;
    logic             partial_q, partial_d;

    logic [1:0]       wr_idx;
    logic             close;
    logic [WIDTH-1:0] shadow_in [4];
    logic [3:0]       fill_in;

    // In idle the pointer is known to be zero; the enum makes that explicit.
    assign wr_idx = (state_q == StIdle) ? 2'd0 : ptr_q;
    assign close  = valid_in && ((wr_idx == 2'd3) || last_in);

    // Shadow contents including the byte arriving this cycle.
    always_comb begin
        shadow_in = shadow_q;
        fill_in   = fill_q;
        if (valid_in) begin
            shadow_in[wr_idx] = data_in;
            fill_in[wr_idx]   = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        shadow_d      = shadow_q;
        fill_d        = fill_q;
        dout_d        = dout_q;
        vout_d        = 4'b0000;
        group_valid_d = 1'b0;
        partial_d     = 1'b0;

        unique case (state_q)
            StIdle, StFill: begin
                if (close) begin
                    dout_d        = shadow_in;
                    vout_d        = fill_in;
                    group_valid_d = 1'b1;
                    partial_d     = ~&fill_in;
                    ptr_d         = 2'd0;
                    fill_d        = 4'b0000;
                    for (int i = 0; i < 4; i++) begin
                        shadow_d[i] = '0;
                    end
                    state_d       = StIdle;
                end else if (valid_in) begin
                    shadow_d = shadow_in;
                    fill_d   = fill_in;
                    ptr_d    = wr_idx + 2'd1;
                    state_d  = StFill;
                end
            end
            default: begin
                state_d = StIdle;
                ptr_d   = 2'd0;
                fill_d  = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            ptr_q         <= 2'd0;
            fill_q        <= 4'b0000;
            vout_q        <= 4'b0000;
            group_valid_q <= 1'b0;
            partial_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
                dout_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            fill_q        <= fill_d;
            vout_q        <= vout_d;
            group_valid_q <= group_valid_d;
            partial_q     <= partial_d;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= shadow_d[i];
                dout_q[i]   <= dout_d[i];
            end
        end
    end

    assign data_out0   = dout_q[0];
    assign data_out1   = dout_q[1];
    assign data_out2   = dout_q[2];
    assign data_out3   = dout_q[3];
    assign valid_out0  = vout_q[0];
    assign valid_out1  = vout_q[1];
    assign valid_out2  = vout_q[2];
    assign valid_out3  = vout_q[3];
    assign group_valid = group_valid_q;
    assign partial     = partial_q;

endmodule

// File: tb/tb_demux_1a4.sv
// Directed bench for demux_1a4: drives bytes on the falling edge, checks outputs 1ns after
// each rising edge against hand-computed expectations.
module tb_demux_1a4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       last_in;
    logic [7:0] data_out0, data_out1, data_out2, data_out3;
    logic       valid_out0, valid_out1, valid_out2, valid_out3;
    logic       group_valid;
    logic       partial;

    int checks = 0;
    int errors = 0;

    demux_1a4 #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .last_in    (last_in),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .data_out2  (data_out2),
        .data_out3  (data_out3),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .valid_out2 (valid_out2),
        .valid_out3 (valid_out3),
        .group_valid(group_valid),
        .partial    (partial)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [7:0] d, input logic v, input logic l);
        @(negedge clk);
        data_in  = d;
        valid_in = v;
        last_in  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] exp_data, input logic [3:0] exp_v,
                       input logic exp_gv, input logic exp_part);
        logic [31:0] obs_data;
        logic [3:0]  obs_v;
        obs_data = {data_out3, data_out2, data_out1, data_out0};
        obs_v    = {valid_out3, valid_out2, valid_out1, valid_out0};
        checks++;
        assert (obs_data === exp_data) else begin
            errors++;
            $error("FAIL %s data observed=%h expected=%h", tag, obs_data, exp_data);
        end
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s valid observed=%b expected=%b", tag, obs_v, exp_v);
        end
        checks++;
        assert (group_valid === exp_gv) else begin
            errors++;
            $error("FAIL %s group_valid observed=%b expected=%b", tag, group_valid, exp_gv);
        end
        checks++;
        assert (partial === exp_part) else begin
            errors++;
            $error("FAIL %s partial observed=%b expected=%b", tag, partial, exp_part);
        end
    endtask

    initial begin
        reset    = 1'b1;
        data_in  = 8'h00;
        valid_in = 1'b0;
        last_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 32'h0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // 1: full group
        step(8'hFF, 1'b1, 1'b0);
        step(8'hEE, 1'b1, 1'b0);
        step(8'hDD, 1'b1, 1'b0);
        chk("t1_pre", 32'h0, 4'b0000, 1'b0, 1'b0);
        step(8'hCC, 1'b1, 1'b0);
        chk("t1_group", 32'hCCDDEEFF, 4'b1111, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        chk("t1_hold", 32'hCCDDEEFF, 4'b0000, 1'b0, 1'b0);

        // 2: back-to-back groups
        step(8'hFF, 1'b1, 1'b0);
        step(8'hEE, 1'b1, 1'b0);
        step(8'hDD, 1'b1, 1'b0);
        step(8'hCC, 1'b1, 1'b0);
        chk("t2_g1", 32'hCCDDEEFF, 4'b1111, 1'b1, 1'b0);
        step(8'hBB, 1'b1, 1'b0);
        chk("t2_mid", 32'hCCDDEEFF, 4'b0000, 1'b0, 1'b0);
        step(8'hAA, 1'b1, 1'b0);
        step(8'h99, 1'b1, 1'b0);
        step(8'h88, 1'b1, 1'b0);
        chk("t2_g2", 32'h8899AABB, 4'b1111, 1'b1, 1'b0);

        // 3: gaps inside a group; junk data while idle, last_in ignored
        step(8'hBB, 1'b1, 1'b0);
        step(8'h5C, 1'b0, 1'b1);
        step(8'hC5, 1'b0, 1'b0);
        chk("t3_gap", 32'h8899AABB, 4'b0000, 1'b0, 1'b0);
        step(8'hAA, 1'b1, 1'b0);
        step(8'h99, 1'b1, 1'b0);
        step(8'h3E, 1'b0, 1'b1);
        step(8'h88, 1'b1, 1'b0);
        chk("t3_group", 32'h8899AABB, 4'b1111, 1'b1, 1'b0);

        // 4: partial groups
        step(8'h77, 1'b1, 1'b1);
        chk("t4_one", 32'h00000077, 4'b0001, 1'b1, 1'b1);
        step(8'h11, 1'b1, 1'b0);
        chk("t4_mid", 32'h00000077, 4'b0000, 1'b0, 1'b0);
        step(8'h22, 1'b1, 1'b1);
        chk("t4_two", 32'h00002211, 4'b0011, 1'b1, 1'b1);

        // 5: last_in on the fourth byte
        step(8'h01, 1'b1, 1'b0);
        step(8'h02, 1'b1, 1'b0);
        step(8'h03, 1'b1, 1'b0);
        step(8'h04, 1'b1, 1'b1);
        chk("t5_full", 32'h04030201, 4'b1111, 1'b1, 1'b0);

        // 6: asynchronous reset mid-group
        step(8'h5A, 1'b1, 1'b0);
        step(8'h6B, 1'b1, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("t6_async", 32'h0, 4'b0000, 1'b0, 1'b0);
        reset = 1'b0;
        step(8'h11, 1'b1, 1'b0);
        step(8'h22, 1'b1, 1'b0);
        step(8'h33, 1'b1, 1'b0);
        chk("t6_pre", 32'h0, 4'b0000, 1'b0, 1'b0);
        step(8'h44, 1'b1, 1'b0);
        chk("t6_group", 32'h44332211, 4'b1111, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        chk("t6_hold", 32'h44332211, 4'b0000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
